// File: rtl/multi_voice_mixer.sv
// Frame-synchronised voice mixer: issues per-frame sample requests and the beat tick,
// collects one sample per voice, attenuates, sums, saturates and presents the mix.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | latch voice samples, wait for the next sample request
// MIX     | accumulate one voice per cycle from the frame snapshot
// OUT     | saturated mix on sample_out, new_sample_generated high
module multi_voice_mixer #(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BEAT_COUNT   = 1000,
    parameter int BEAT_WIDTH   = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               play,
    input  logic                               new_frame,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
    input  logic [NUM_VOICES-1:0]              voice_valid,
    input  logic [NUM_VOICES-1:0]              voice_enable,
    input  logic [3*NUM_VOICES-1:0]            gain_shift,
    output logic                               generate_next_sample,
    output logic                               beat,
    output logic [SAMPLE_WIDTH-1:0]            sample_out,
    output logic                               new_sample_generated,
    output logic                               clip,
    output logic [NUM_VOICES-1:0]              missed,
    output logic                               overrun
);

    localparam int SW    = SAMPLE_WIDTH;
    localparam int ACC_W = SW + $clog2(NUM_VOICES);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_VOICES - 1);
    localparam logic [BEAT_WIDTH-1:0] BEAT_LAST = BEAT_WIDTH'(BEAT_COUNT - 1);
    localparam logic [SW-1:0]         OUT_MAX   = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0]         OUT_MIN   = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SW+1){1'b1}}, {(SW-1){1'b0}}};

    typedef enum logic [1:0] {S_COLLECT, S_MIX, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic                    frame_d_q;
    logic                    gen_q, gen_d;
    logic [BEAT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic signed [SW-1:0]    hold_q [NUM_VOICES];
    logic signed [SW-1:0]    hold_d [NUM_VOICES];
    logic signed [SW-1:0]    snap_q [NUM_VOICES];
    logic signed [SW-1:0]    snap_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   got_q, got_d;
    logic [NUM_VOICES-1:0]   snap_got_q, snap_got_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SW-1:0]           sample_q, sample_d;
    logic                    clip_q, clip_d;
    logic [NUM_VOICES-1:0]   missed_q, missed_d;
    logic                    overrun_q, overrun_d;

    logic                    beat_wrap;
    logic signed [SW-1:0]    shifted;
    logic signed [ACC_W-1:0] contrib;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_COLLECT;
            frame_d_q  <= 1'b0;
            gen_q      <= 1'b0;
            beat_cnt_q <= '0;
            hold_q     <= '{default: '0};
            snap_q     <= '{default: '0};
            got_q      <= '0;
            snap_got_q <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            sample_q   <= '0;
            clip_q     <= 1'b0;
            missed_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_d_q  <= new_frame;
            gen_q      <= gen_d;
            beat_cnt_q <= beat_cnt_d;
            hold_q     <= hold_d;
            snap_q     <= snap_d;
            got_q      <= got_d;
            snap_got_q <= snap_got_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            sample_q   <= sample_d;
            clip_q     <= clip_d;
            missed_q   <= missed_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (gen_q) state_d = S_MIX;
            S_MIX:     if (idx_q == LAST_IDX) state_d = S_OUT;
            S_OUT:     state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        gen_d      = new_frame & ~frame_d_q;
        beat_wrap  = gen_q & play & (beat_cnt_q == BEAT_LAST);
        beat_cnt_d = beat_cnt_q;
        if (gen_q && play) begin
            beat_cnt_d = beat_wrap ? '0 : beat_cnt_q + 1'b1;
        end

        hold_d     = hold_q;
        snap_d     = snap_q;
        got_d      = got_q;
        snap_got_d = snap_got_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        sample_d   = sample_q;
        clip_d     = clip_q;
        missed_d   = missed_q;
        overrun_d  = overrun_q | (gen_q & (state_q != S_COLLECT));

        shifted = snap_q[idx_q] >>> gain_shift[idx_q*3 +: 3];
        contrib = (voice_enable[idx_q] & snap_got_q[idx_q] & play) ? ACC_W'(shifted) : '0;

        if (state_q == S_COLLECT) begin
            if (gen_q) begin
                snap_d     = hold_q;
                snap_got_d = got_q;
                got_d      = '0;
                acc_d      = '0;
                idx_d      = '0;
                missed_d   = missed_q | (voice_enable & ~got_q);
            end
            // Same-cycle valids belong to the next frame, so they land after the clear.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_valid[i]) begin
                    hold_d[i] = voice_samples[i*SW +: SW];
                    got_d[i]  = 1'b1;
                end
            end
        end

        if (state_q == S_MIX) begin
            acc_d = acc_q + contrib;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                if (acc_d > SAT_MAX) begin
                    sample_d = OUT_MAX;
                    clip_d   = 1'b1;
                end else if (acc_d < SAT_MIN) begin
                    sample_d = OUT_MIN;
                    clip_d   = 1'b1;
                end else begin
                    sample_d = acc_d[SW-1:0];
                    clip_d   = 1'b0;
                end
            end
        end
    end

    always_comb begin
        generate_next_sample = gen_q;
        beat                 = beat_wrap;
        sample_out           = sample_q;
        new_sample_generated = (state_q == S_OUT);
        clip                 = (state_q == S_OUT) & clip_q;
        missed               = missed_q;
        overrun              = overrun_q;
    end

endmodule

// File: doc/multi_voice_mixer.md
Name: multi_voice_mixer

Overview:
Parametrised successor to the single-voice note-to-codec path. It generates the per-frame sample request and the beat tick. It collects one signed sample per frame from each of NUM_VOICES note players and applies a per-voice attenuation shift. It then sums and saturates the voices and presents one frame-synchronised sample to the codec. It sits between the note-player bank and the codec interface, replacing the separate beat divider and the single-sample conditioner.

Parameters:
NUM_VOICES, 4, number of voice inputs (1..16)
SAMPLE_WIDTH, 16, signed sample width in and out
BEAT_COUNT, 1000, sample requests per beat tick; reduce to 100 for simulation
BEAT_WIDTH, 10, width of the beat counter; must hold BEAT_COUNT-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clears all state
play  in  1  1 = run, 0 = pause
new_frame  in  1  raw codec frame strobe, level may last several cycles
voice_samples  in  NUM_VOICES*SAMPLE_WIDTH  packed signed samples; voice i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
voice_valid  in  NUM_VOICES  1-cycle pulse per voice: sample on the bus is new
voice_enable  in  NUM_VOICES  voice included in the mix when 1
gain_shift  in  3*NUM_VOICES  per-voice arithmetic right shift 0..7
generate_next_sample  out  1  1-cycle request to all voices for the next sample
beat  out  1  1-cycle beat tick
sample_out  out  SAMPLE_WIDTH  mixed sample to codec, held between updates
new_sample_generated  out  1  1-cycle pulse when sample_out updates
clip  out  1  high with new_sample_generated when saturation occurred
missed  out  NUM_VOICES  sticky per voice: enabled voice failed to deliver in a frame; cleared by reset only
overrun  out  1  sticky: frame edge arrived while mixing; cleared by reset only

Behaviour:
- Reset values: all outputs 0; holding registers, got flags, accumulator and beat counter 0; FSM in COLLECT.
- Frame edge: new_frame is registered to new_frame_d. A rising edge (new_frame & ~new_frame_d) registers generate_next_sample = 1 on the next cycle, for exactly 1 cycle. A held-high new_frame produces one pulse only.
- Beat: on each generate_next_sample with play = 1, the counter increments. At BEAT_COUNT-1 it wraps to 0 and beat pulses in the same cycle as the wrap. With play = 0 the counter holds.
- Collection:
  - In COLLECT, voice_valid[i] latches voice sample i into hold[i] and sets got[i].
  - A repeated valid in the same frame overwrites hold[i].
  - voice_valid is ignored while in MIX.
- FSM states: COLLECT, MIX, OUT.
- COLLECT -> MIX on generate_next_sample.
  - Snapshot got and hold into the working set, clear got.
  - Clear the accumulator and set the voice index to 0.
  - For each i with voice_enable[i] = 1 and got[i] = 0, set missed[i].
- MIX: one voice per cycle for NUM_VOICES cycles.
  - acc += (enable[i] & got_snap[i] & play) ? (hold[i] >>> gain_shift[i]) : 0.
  - acc is signed, SAMPLE_WIDTH + clog2(NUM_VOICES) bits; shift is sign-extending.
  - After the last voice, go to OUT.
- OUT: 1 cycle.
  - sample_out = acc saturated to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - clip = 1 if saturation applied.
  - new_sample_generated = 1.
  - Return to COLLECT.
- Latency: generate_next_sample in cycle T gives new_sample_generated in cycle T+NUM_VOICES+1. sample_out is stable otherwise.
- Paused (play = 0): frames still request and mix, but all contributions are 0, so sample_out becomes 0 at the next mix.
- A frame edge detected while in MIX or OUT:
  - generate_next_sample is still issued and overrun is set.
  - The frame is not mixed; the FSM stays on its current pass.
- voice_valid in the same cycle as generate_next_sample is latched into the new frame, not the snapshot.
- Reset mid-mix aborts the pass: no new_sample_generated, and sample_out goes to 0.

Test Plan:
- NUM_VOICES=4. Voices deliver 1000, 2000, -500, 0 with gain 0, all enabled, play=1, new_frame edge -> generate_next_sample 1 cycle after edge; new_sample_generated 5 cycles later; sample_out=2500, clip=0.
- Voices 0..3 each 16'h7000, gain 0 -> sample_out=16'h7FFF, clip=1. Repeat with 16'h9000 -> 16'h8000, clip=1.
- gain_shift voice0=2 with sample -4000, others disabled -> sample_out=-1000. Voice1 enabled but silent -> missed[1]=1 and stays 1 after later good frames.
- BEAT_COUNT=4 with 10 frame edges at play=1 -> beat pulses on requests 4 and 8. Drop play for 3 frames -> no beat, counter holds, sample_out=0 after the first paused mix.
- new_frame held high 20 cycles -> one request. Second edge injected during MIX -> overrun=1, request issued, only one new_sample_generated.
- Reset asserted mid-MIX -> next cycle all outputs 0; next frame mixes correctly.
